ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, requests to send,
// shifts a byte out on device clock edges and checks the device ACK.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int CLK_KHZ     = 1000,
  parameter int INHIBIT_US  = 100,
  parameter int START_TO_US = 15000,
  parameter int FRAME_TO_US = 2000
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iStart,
  input  logic [7:0] iData,
  input  logic       iPs2_Clk,
  input  logic       iPs2_Data,
  output logic       oPs2_Clk_Oe,
  output logic       oPs2_Data_Oe,
  output logic       oBusy,
  output logic       oDone,
  output logic       oError,
  output logic [2:0] oState
);

  localparam int INHIBIT_CYC = CLK_KHZ * INHIBIT_US / 1000;
  localparam int START_CYC   = CLK_KHZ * START_TO_US / 1000;
  localparam int FRAME_CYC   = CLK_KHZ * FRAME_TO_US / 1000;
  localparam int MAX_CYC_A   = (START_CYC > FRAME_CYC) ? START_CYC : FRAME_CYC;
  localparam int MAX_CYC     = (MAX_CYC_A > INHIBIT_CYC) ? MAX_CYC_A : INHIBIT_CYC;
  localparam int TW          = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] TIMER_MAX     = TW'(MAX_CYC);
  localparam logic [TW-1:0] INHIBIT_LAST  = TW'(INHIBIT_CYC - 1);
  localparam logic [TW-1:0] START_BIT_AT  = TW'((INHIBIT_CYC >= 2) ? INHIBIT_CYC - 2 : 0);
  localparam logic [TW-1:0] START_LAST    = TW'(START_CYC - 1);
  localparam logic [TW-1:0] FRAME_LAST    = TW'(FRAME_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQ       = 3'd2,
    S_TX        = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t          r_state;
  logic [1:0]      r_clk_sync;
  logic [1:0]      r_data_sync;
  logic [2:0]      r_clk_hist;
  logic [2:0]      r_data_hist;
  logic            r_clk_filt_d;
  logic [TW-1:0]   r_timer;
  logic [3:0]      r_bit_idx;
  logic [7:0]      r_data;
  logic            r_parity;
  logic            r_ack_bit;
  logic            r_clk_oe;
  logic            r_data_oe;
  logic            r_busy;
  logic            r_done;
  logic            r_error;

  logic            w_clk_filt;
  logic            w_data_filt;
  logic            w_clk_fall;
  logic [TW-1:0]   w_timer_next;
  logic            w_start_exp;
  logic            w_frame_exp;
  logic            w_abort;
  logic [3:0]      w_bit_next;
  logic            w_tx_oe;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Line conditioning: both lines idle high, so every stage resets to 1 and
  // no phantom edge appears when reset is released.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_clk_sync   <= 2'b11;
      r_data_sync  <= 2'b11;
      r_clk_hist   <= 3'b111;
      r_data_hist  <= 3'b111;
      r_clk_filt_d <= 1'b1;
    end else begin
      r_clk_sync   <= {r_clk_sync[0], iPs2_Clk};
      r_data_sync  <= {r_data_sync[0], iPs2_Data};
      r_clk_hist   <= {r_clk_hist[1:0], r_clk_sync[1]};
      r_data_hist  <= {r_data_hist[1:0], r_data_sync[1]};
      r_clk_filt_d <= w_clk_filt;
    end
  end

  assign w_clk_filt  = maj3(r_clk_hist);
  assign w_data_filt = maj3(r_data_hist);
  assign w_clk_fall  = r_clk_filt_d & ~w_clk_filt;

  assign w_timer_next = (r_timer == TIMER_MAX) ? r_timer : r_timer + 1'b1;
  assign w_start_exp  = (r_timer >= START_LAST);
  assign w_frame_exp  = (r_timer >= FRAME_LAST);

  // Timeouts win over a coincident device edge.
  always_comb begin
    w_abort = 1'b0;
    case (r_state)
      S_REQ:       w_abort = w_start_exp;
      S_TX:        w_abort = w_frame_exp;
      S_ACK:       w_abort = w_frame_exp | r_ack_bit;
      S_WAIT_IDLE: w_abort = w_frame_exp;
      default:     w_abort = 1'b0;
    endcase
  end

  // Bit index n is driven after falling edge n+1: 0..7 data, 8 parity, 9 stop.
  always_comb begin
    w_bit_next = r_bit_idx + 4'd1;
    w_tx_oe    = 1'b0;
    case (w_bit_next)
      4'd0, 4'd1, 4'd2, 4'd3,
      4'd4, 4'd5, 4'd6, 4'd7: w_tx_oe = ~r_data[w_bit_next[2:0]];
      4'd8:                   w_tx_oe = ~r_parity;
      default:                w_tx_oe = 1'b0;
    endcase
  end

  // Request handshake: iStart is taken only while oBusy is low (IDLE); oBusy
  // then stays high until the cycle that oDone or oError pulses.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_data    <= '0;
      r_parity  <= 1'b0;
      r_ack_bit <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      if (w_abort) begin
        r_state   <= S_IDLE;
        r_clk_oe  <= 1'b0;
        r_data_oe <= 1'b0;
        r_busy    <= 1'b0;
        r_error   <= 1'b1;
        r_timer   <= '0;
        r_bit_idx <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_timer   <= '0;
            r_bit_idx <= '0;
            if (iStart) begin
              r_data   <= iData;
              r_parity <= ~^iData;
              r_busy   <= 1'b1;
              r_clk_oe <= 1'b1;
              r_state  <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            r_timer <= w_timer_next;
            if (r_timer >= START_BIT_AT) r_data_oe <= 1'b1;
            if (r_timer == INHIBIT_LAST) begin
              r_clk_oe <= 1'b0;
              r_timer  <= '0;
              r_state  <= S_REQ;
            end
          end
          S_REQ: begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b1;
            r_timer   <= w_timer_next;
            if (w_clk_fall) begin
              r_bit_idx <= '0;
              r_data_oe <= ~r_data[0];
              r_timer   <= '0;
              r_state   <= S_TX;
            end
          end
          S_TX: begin
            r_timer <= w_timer_next;
            if (w_clk_fall) begin
              if (r_bit_idx == 4'd9) begin
                r_ack_bit <= w_data_filt;
                r_data_oe <= 1'b0;
                r_state   <= S_ACK;
              end else begin
                r_bit_idx <= w_bit_next;
                r_data_oe <= w_tx_oe;
              end
            end
          end
          S_ACK: begin
            r_timer <= w_timer_next;
            r_state <= S_WAIT_IDLE;
          end
          S_WAIT_IDLE: begin
            r_timer <= w_timer_next;
            if (w_clk_filt && w_data_filt) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign oPs2_Clk_Oe  = r_clk_oe;
  assign oPs2_Data_Oe = r_data_oe;
  assign oBusy        = r_busy;
  assign oDone        = r_done;
  assign oError       = r_error;
  assign oState       = r_state;

endmodule
